// File: rtl/gpu_pkg.sv
// Shared types and width constants for the GPU drawing units.
package gpu_pkg;

  localparam int WIDTH_BITS   = 10;
  localparam int HEIGHT_BITS  = 9;
  localparam int CHANNEL_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic [CHANNEL_BITS-1:0] r;
    logic [CHANNEL_BITS-1:0] g;
    logic [CHANNEL_BITS-1:0] b;
  } color_t;

endpackage

// File: rtl/gpu_raster_counter.sv
// Loadable x/y raster counter: x runs xmin..xmax, then y steps; bounds latched on load.
module gpu_raster_counter
  import gpu_pkg::*;
#(
  parameter int XW = WIDTH_BITS,
  parameter int YW = HEIGHT_BITS
) (
  input  logic          clk,
  input  logic          srst_i,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic [XW-1:0] xmin_i,
  input  logic [XW-1:0] xmax_i,
  input  logic [YW-1:0] ymin_i,
  input  logic [YW-1:0] ymax_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] y_q, y_d, ymax_q, ymax_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymax_d = ymax_q;
    if (load_i) begin
      x_d    = xmin_i;
      y_d    = ymin_i;
      xmin_d = xmin_i;
      xmax_d = xmax_i;
      ymax_d = ymax_i;
    end else if (advance_i) begin
      if (x_q < xmax_q) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = xmin_q;
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymax_q <= ymax_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == xmax_q) && (y_q == ymax_q);

endmodule

// File: rtl/gpu_fill_rect.sv
// Rectangle fill engine: raster-walks an inclusive rectangle, one pixel write per handshake.
// Optional screen clipping is enabled by defining GPU_FILL_CLIP_EN.
module gpu_fill_rect
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [WIDTH_BITS-1:0]     x1_i,
  input  logic [WIDTH_BITS-1:0]     x2_i,
  input  logic [HEIGHT_BITS-1:0]    y1_i,
  input  logic [HEIGHT_BITS-1:0]    y2_i,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  input  logic                      run_i,
  input  logic                      wr_ready_i,
  output logic                      wr_en_o,
  output logic [WIDTH_BITS-1:0]     wr_x_o,
  output logic [HEIGHT_BITS-1:0]    wr_y_o,
  output logic [3*CHANNEL_BITS-1:0] wr_color_o,
  output logic                      busy_o,
  output logic                      finished_o
);

`ifdef GPU_FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif
  localparam logic [WIDTH_BITS-1:0]  X_LIM = WIDTH_BITS'(SCREEN_W - 1);
  localparam logic [HEIGHT_BITS-1:0] Y_LIM = HEIGHT_BITS'(SCREEN_H - 1);

  fill_state_t state_q, state_d;
  logic [WIDTH_BITS-1:0]  xa_q, xb_q;
  logic [HEIGHT_BITS-1:0] ya_q, yb_q;
  color_t                 color_q;

  logic [WIDTH_BITS-1:0]  xmin, xmax, xmin_c, xmax_c;
  logic [HEIGHT_BITS-1:0] ymin, ymax, ymin_c, ymax_c;
  logic empty, load, advance, last;

  assign xmin = (xa_q < xb_q) ? xa_q : xb_q;
  assign xmax = (xa_q < xb_q) ? xb_q : xa_q;
  assign ymin = (ya_q < yb_q) ? ya_q : yb_q;
  assign ymax = (ya_q < yb_q) ? yb_q : ya_q;

  // A rectangle starting past the screen edge has nothing visible to draw.
  assign empty  = CLIP_EN && ((xmin > X_LIM) || (ymin > Y_LIM));
  assign xmin_c = (CLIP_EN && xmin > X_LIM) ? X_LIM : xmin;
  assign xmax_c = (CLIP_EN && xmax > X_LIM) ? X_LIM : xmax;
  assign ymin_c = (CLIP_EN && ymin > Y_LIM) ? Y_LIM : ymin;
  assign ymax_c = (CLIP_EN && ymax > Y_LIM) ? Y_LIM : ymax;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE:  if (run_i) state_d = ST_SETUP;
      ST_SETUP: begin
        load    = 1'b1;
        state_d = empty ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        if (wr_ready_i) begin
          if (last) state_d = ST_DONE;
          else      advance = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= ST_IDLE;
      xa_q    <= '0;
      xb_q    <= '0;
      ya_q    <= '0;
      yb_q    <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && run_i) begin
        xa_q    <= x1_i;
        xb_q    <= x2_i;
        ya_q    <= y1_i;
        yb_q    <= y2_i;
        color_q <= '{r: r_i, g: g_i, b: b_i};
      end
    end
  end

  gpu_raster_counter #(
    .XW(WIDTH_BITS),
    .YW(HEIGHT_BITS)
  ) u_raster (
    .clk       (clk),
    .srst_i    (n_rst),
    .load_i    (load),
    .advance_i (advance),
    .xmin_i    (xmin_c),
    .xmax_i    (xmax_c),
    .ymin_i    (ymin_c),
    .ymax_i    (ymax_c),
    .x_o       (wr_x_o),
    .y_o       (wr_y_o),
    .last_o    (last)
  );

  assign wr_en_o    = (state_q == ST_FILL);
  assign finished_o = (state_q == ST_DONE);
  assign busy_o     = (state_q != ST_IDLE);
  assign wr_color_o = color_q;

endmodule

// File: tb/tb_gpu_fill_rect.sv
// Scoreboard bench for gpu_fill_rect: reference model queues expected pixels, monitor checks them.
module tb_gpu_fill_rect;
  import gpu_pkg::*;

  localparam int SW = 640;
  localparam int SH = 480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      n_rst;
  logic [WIDTH_BITS-1:0]     x1_i, x2_i;
  logic [HEIGHT_BITS-1:0]    y1_i, y2_i;
  logic [CHANNEL_BITS-1:0]   r_i, g_i, b_i;
  logic                      run_i, wr_ready_i;
  logic                      wr_en_o, busy_o, finished_o;
  logic [WIDTH_BITS-1:0]     wr_x_o;
  logic [HEIGHT_BITS-1:0]    wr_y_o;
  logic [3*CHANNEL_BITS-1:0] wr_color_o;

  gpu_fill_rect #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .n_rst(n_rst),
    .x1_i(x1_i), .x2_i(x2_i), .y1_i(y1_i), .y2_i(y2_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .run_i(run_i), .wr_ready_i(wr_ready_i),
    .wr_en_o(wr_en_o), .wr_x_o(wr_x_o), .wr_y_o(wr_y_o),
    .wr_color_o(wr_color_o), .busy_o(busy_o), .finished_o(finished_o)
  );

  typedef struct packed {
    logic                      done;
    logic [WIDTH_BITS-1:0]     x;
    logic [HEIGHT_BITS-1:0]    y;
    logic [3*CHANNEL_BITS-1:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: inclusive rectangle walked row by row, optional screen clip.
  function automatic int model_rect(int x1, int y1, int x2, int y2, logic [23:0] c);
    int xl, xh, yl, yh, n;
    exp_t e;
    xl = (x1 < x2) ? x1 : x2;  xh = (x1 < x2) ? x2 : x1;
    yl = (y1 < y2) ? y1 : y2;  yh = (y1 < y2) ? y2 : y1;
    n = 0;
`ifdef GPU_FILL_CLIP_EN
    if (xl > SW - 1 || yl > SH - 1) begin
      xh = xl - 1;
      yh = yl - 1;
    end
    if (xh > SW - 1) xh = SW - 1;
    if (yh > SH - 1) yh = SH - 1;
`endif
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        e.done = 1'b0;
        e.x = WIDTH_BITS'(x);
        e.y = HEIGHT_BITS'(y);
        e.c = c;
        sb.push_back(e);
        n++;
      end
    end
    e = '0;
    e.done = 1'b1;
    sb.push_back(e);
    return n;
  endfunction

  initial begin : rdy_drv
    wr_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       wr_ready_i = 1'b1;
        1:       wr_ready_i = ~wr_ready_i;
        default: wr_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    logic hold_v;
    logic [42:0] held;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && wr_en_o)
          check("held_data", 64'({wr_x_o, wr_y_o, wr_color_o}), 64'(held));
        if (wr_en_o && wr_ready_i) begin
          if (sb.size() == 0) begin
            check("unexpected_write", 64'({wr_x_o, wr_y_o}), 64'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("pixel", 64'({1'b0, wr_x_o, wr_y_o, wr_color_o}), 64'(e));
          end
        end
        if (finished_o) begin
          if (sb.size() == 0) begin
            check("unexpected_finished", 64'(finished_o), 64'd0);
          end else begin
            e = sb.pop_front();
            check("finished_order", 64'({finished_o, wr_en_o}), 64'({e.done, 1'b0}));
          end
        end
        hold_v = wr_en_o && !wr_ready_i;
        held   = {wr_x_o, wr_y_o, wr_color_o};
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_finished"}, 64'(finished_o), 64'd0);
    check({tag, "_xy"}, 64'({wr_x_o, wr_y_o}), 64'd0);
    check({tag, "_color"}, 64'(wr_color_o), 64'd0);
  endtask

  task automatic start_rect(input int x1, input int y1, input int x2, input int y2,
                            input logic [23:0] c);
    @(posedge clk);
    #1;
    x1_i = WIDTH_BITS'(x1);  x2_i = WIDTH_BITS'(x2);
    y1_i = HEIGHT_BITS'(y1); y2_i = HEIGHT_BITS'(y2);
    {r_i, g_i, b_i} = c;
    run_i = 1'b1;
    @(posedge clk);
    #1;
    run_i = 1'b0;
    x1_i = WIDTH_BITS'($urandom); x2_i = WIDTH_BITS'($urandom);
    y1_i = HEIGHT_BITS'($urandom); y2_i = HEIGHT_BITS'($urandom);
    {r_i, g_i, b_i} = 24'($urandom);
  endtask

  task automatic run_rect(input int x1, input int y1, input int x2, input int y2,
                          input logic [23:0] c, input int mode, input bit rerun);
    int p, k, busy_n;
    bit done;
    rdy_mode = mode;
    p = model_rect(x1, y1, x2, y2, c);
    start_rect(x1, y1, x2, y2, c);
    k = 0; busy_n = 0; done = 1'b0;
    while (!done && k < 4000) begin
      @(negedge clk);
      k++;
      if (busy_o) busy_n++;
      if (mode == 0 && p > 0 && k <= 2) check("wr_en_latency", 64'(wr_en_o), 64'(k == 2));
      if (rerun && k == 3) run_i = 1'b1;
      if (rerun && k == 4) run_i = 1'b0;
      if (finished_o) done = 1'b1;
    end
    run_i = 1'b0;
    if (!done) begin
      check("finish_timeout", 64'(k), 64'd0);
    end else begin
      if (mode == 0) check("done_cycle", 64'(k), 64'(p + 2));
      check("busy_cycles", 64'(busy_n), 64'(k));
    end
    @(negedge clk);
    check("idle_after", 64'(busy_o), 64'd0);
    $display("rect (%0d,%0d)-(%0d,%0d) mode=%0d pixels=%0d cycles=%0d", x1, y1, x2, y2, mode, p, k);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int x, y, dx, dy, m, p0;
    n_rst = 1'b1; run_i = 1'b0;
    x1_i = '0; x2_i = '0; y1_i = '0; y2_i = '0; r_i = '0; g_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 n_rst = 1'b0;

    run_rect(15, 150, 17, 151, {8'd10, 8'd9, 8'd8}, 0, 1'b0);
    run_rect(299, 250, 297, 249, 24'h123456, 0, 1'b0);
    run_rect(0, 0, 0, 0, 24'hABCDEF, 0, 1'b0);
    run_rect(100, 100, 101, 101, 24'h0F0F0F, 1, 1'b0);
    run_rect(20, 20, 25, 22, 24'h777777, 0, 1'b1);

    // Reset mid-fill: partial writes then abandoned, no finished pulse.
    rdy_mode = 0;
    p0 = model_rect(2, 3, 4, 5, 24'h010203);
    start_rect(2, 3, 4, 5, 24'h010203);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midfill_reset");
    @(posedge clk);
    #1 n_rst = 1'b0;
    sb.delete();
    $display("reset mid-fill of %0d-pixel rect", p0);
    repeat (5) @(negedge clk);
    check("post_reset_idle", 64'({busy_o, wr_en_o, finished_o}), 64'd0);
    run_rect(2, 3, 4, 5, 24'h010203, 0, 1'b0);

`ifdef GPU_FILL_CLIP_EN
    run_rect(638, 0, 700, 0, 24'h445566, 0, 1'b0);
    run_rect(650, 0, 700, 0, 24'h445566, 0, 1'b0);
`endif

    for (int i = 0; i < 25; i++) begin
      x  = $urandom_range(0, 1018);
      y  = $urandom_range(0, 506);
      dx = $urandom_range(0, 4);
      dy = $urandom_range(0, 4);
      m  = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        run_rect(x + dx, y + dy, x, y, 24'($urandom), m, (dx + 1) * (dy + 1) >= 4);
      else
        run_rect(x, y, x + dx, y + dy, 24'($urandom), m, 1'b0);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
